// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one overlapping pattern-match engine time-shared among
// NCH serial channels by a round-robin arbiter. Each channel keeps its own
// bit history and fill count, so it behaves like a standalone Mealy
// detector. Matches are reported one cycle after the completing bit, tagged
// with the channel, and tallied in a saturating counter.
module seq_detect_sched #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1010,
    parameter int              CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [NCH-1:0]           ch_bit,
    output logic [NCH-1:0]           ch_ready,
    input  logic                     cnt_clr,
    output logic                     match,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     busy
);

    localparam int IDX_W  = $clog2(NCH);
    // PLEN-1 always fits in clog2(PLEN) bits for PLEN >= 2
    localparam int FILL_W = $clog2(PLEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN - 1);

    logic [IDX_W-1:0]  last_gnt;
    logic [PLEN-2:0]   hist [NCH];
    logic [FILL_W-1:0] fill [NCH];

    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic              hit;

    // Channel index reached by stepping off positions past base, modulo NCH.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = (base + off) % NCH;
        return IDX_W'(s);
    endfunction

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        ch_ready = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        if (en) begin
            for (int i = 1; i <= NCH; i++) begin
                if (!gnt_any && ch_valid[wrap_idx(int'(last_gnt), i)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = wrap_idx(int'(last_gnt), i);
                end
            end
        end
        if (gnt_any) ch_ready[gnt_idx] = 1'b1;
    end

    // A match needs a full window: the fill guard stops the zeroed reset
    // history from completing patterns that begin with zeros.
    always_comb begin
        hit = gnt_any
              && ({hist[gnt_idx], ch_bit[gnt_idx]} == PATTERN)
              && (fill[gnt_idx] == FILL_MAX);
    end

    // Per-channel context and arbiter pointer; only the granted channel moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= IDX_W'(NCH - 1);
            for (int c = 0; c < NCH; c++) begin
                hist[c] <= '0;
                fill[c] <= '0;
            end
        end else if (gnt_any) begin
            last_gnt      <= gnt_idx;
            // keep the newest PLEN-1 bits; history survives a match for overlap
            hist[gnt_idx] <= (PLEN-1)'({hist[gnt_idx], ch_bit[gnt_idx]});
            if (fill[gnt_idx] != FILL_MAX)
                fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
        end
    end

    // Registered match report, busy flag and saturating counter. The counter
    // steps on the same edge that raises match, so both become visible together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match     <= 1'b0;
            match_ch  <= '0;
            match_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            match <= hit;
            busy  <= gnt_any;
            if (hit) match_ch <= gnt_idx;
            if (cnt_clr)
                match_cnt <= '0;
            else if (hit && (match_cnt != '1))
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
Time-shares one serial pattern-match engine among NCH independent 1-bit serial input channels. A round-robin arbiter grants one channel per cycle. Each channel's detection context (bit history plus fill count) is stored separately, so every channel behaves as its own overlapping Mealy pattern detector. The block reports every match with its channel ID and keeps a saturating match counter for the detection subsystem.

Parameters:
NCH, 4, number of serial requester channels (2..8)
PLEN, 4, pattern length in bits (2..8)
PATTERN, 4'b1010, pattern to detect; bit PLEN-1 is the earliest-arriving bit
CNT_W, 16, width of the saturating match counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  global enable; when low, no grants are issued
ch_valid  in  NCH  per-channel request; bit c means ch_bit[c] is presented
ch_bit  in  NCH  per-channel serial data bit
ch_ready  out  NCH  one-hot grant, combinational; a transfer occurs on ch_valid[c] & ch_ready[c]
cnt_clr  in  1  synchronous clear of match_cnt
match  out  1  registered one-cycle pulse, pattern completed
match_ch  out  clog2(NCH)  channel that produced match; holds its value when match=0
match_cnt  out  CNT_W  total matches, saturating
busy  out  1  registered; 1 if any grant was issued last cycle

Behaviour:
- Reset (async, immediate) clears: all history regs; all fill counters; match; match_ch; match_cnt; busy. The round-robin pointer last_gnt resets to NCH-1, so channel 0 has first priority.
- Arbitration, combinational, each cycle:
  - If en=0 or ch_valid=0, then ch_ready=0.
  - Otherwise ch_ready is one-hot: the first requesting channel, searching upward from last_gnt+1 mod NCH.
  - On a grant, last_gnt <= the granted index; otherwise last_gnt holds.
- A channel's valid may drop without a grant; there is no data-holding requirement on a requester that was not granted.
- Context update on transfer to channel c:
  - hist[c] <= {hist[c][PLEN-2:0], ch_bit[c]}, PLEN-1 bits stored.
  - fill[c] increments and saturates at PLEN-1.
- Match condition, evaluated combinationally in the transfer cycle: {hist[c], ch_bit[c]} == PATTERN AND fill[c] == PLEN-1.
- Match output, registered, latency 1 cycle after the completing transfer:
  - match=1 and match_ch=c.
  - In all other cycles match=0.
  - At most one match per cycle, since there is only one grant.
- Overlap: history is not cleared on a match. With PATTERN 1010, the stream 101010 yields matches on the 4th and 6th bits, identical to a standalone overlapping Mealy detector.
- Fill guard: the first PLEN-1 bits after reset can never match, even if the pattern contains leading zeros.
- en=0: all contexts and last_gnt hold, and no transfers occur. A match already registered from the previous cycle still appears.
- Counter:
  - On each registered match, match_cnt increments, saturating at 2^CNT_W-1.
  - cnt_clr has priority: if cnt_clr=1 in the same cycle as an increment, match_cnt <= 0 and that match is not counted. The match pulse itself still appears.
- Channels not granted keep their context unchanged.
- Reset mid-stream discards all partial sequences.

Test Plan:
1. PATTERN=1010, only ch0 valid, bits 1,0,1,0,1,0 on consecutive cycles -> ch_ready=0001 every cycle; match=1 with match_ch=0 one cycle after the 4th bit and again one cycle after the 6th; match_cnt=2.
2. All four ch_valid held high -> ch_ready sequence 0001,0010,0100,1000,0001,...; ch2 fed 1,0,1,0 on its grants and other channels fed 0 -> single match, match_ch=2, one cycle after ch2's 4th grant (cycle 15 counting from 0); match_cnt=1.
3. PATTERN=4'b0010, ch1 only, reset then bits 1,0 -> no match (fill guard); continue 0,0,1,0 -> match at the final bit, match_ch=1.
4. ch0 sends 1,0,1; reset asserted asynchronously mid-cycle; then ch0 sends 0 -> no match; outputs are 0 immediately on reset assertion; the next grant goes to ch0.
5. ch0 sends 1,0,1, then en=0 for 5 cycles with ch_valid high -> ch_ready=0, busy=0; en=1 then bit 0 -> match; ch0's context was preserved.
6. CNT_W=4, 17 matches on ch3 -> match_cnt saturates at 15; cnt_clr pulsed in the cycle of an 18th match -> match_cnt=0, match pulse still seen.
